// File: rtl/pipe_pkg.sv
// Shared IF/ID pipeline definitions: NOP encoding, default bubble payload and the IF/ID bundle.
package pipe_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned INSN_W   = 32;
    localparam int unsigned COUNT_W  = 2;

    // addi x0, x0, 0
    localparam logic [INSN_W-1:0] NOP_INSN       = 32'h0000_0013;
    localparam logic [INSN_W-1:0] BUBBLE_DEFAULT = NOP_INSN;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_p4;
        logic [INSN_W-1:0] instr;
        logic [REG_AW-1:0] rd;
    } if_id_t;

    // Number of held entries given the two valid bits.
    function automatic logic [COUNT_W-1:0] occupancy(input logic main_v, input logic skid_v);
        return COUNT_W'(main_v) + COUNT_W'(skid_v);
    endfunction

endpackage

// File: rtl/dffe_sr.sv
// Enable flop with synchronous active-high reset to a parameterised value.
module dffe_sr #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// Two-entry skid pipeline register: full throughput, registered in_ready, bubble on empty.
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = XLEN,
    parameter logic [31:0] BUBBLE = BUBBLE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE);

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;

    logic             clr_c;
    logic             in_xfer_c;
    logic             out_xfer_c;
    logic             main_load_c;
    logic             skid_en_c;
    logic             skid_data_en_c;
    logic             main_valid_d_c;
    logic [WIDTH-1:0] main_data_d_c;
    logic             skid_valid_d_c;
    logic             main_valid_nx_c;
    logic             skid_valid_nx_c;
    logic [1:0]       count_d_c;

    // Flush shares the synchronous clear path, so rst and flush leave identical state.
    always_comb begin
        clr_c           = rst | flush;
        in_xfer_c       = in_valid & ~skid_valid;
        out_xfer_c      = main_valid & out_ready;
        main_load_c     = ~main_valid | out_xfer_c;

        main_valid_d_c  = skid_valid | in_xfer_c;
        main_data_d_c   = BUBBLE_W;
        if (skid_valid) begin
            main_data_d_c = skid_data;
        end else if (in_xfer_c) begin
            main_data_d_c = in_data;
        end

        // Skid drains into main whenever main frees; otherwise it catches the accepted input.
        skid_en_c       = main_load_c | in_xfer_c;
        skid_valid_d_c  = ~main_load_c;
        skid_data_en_c  = in_xfer_c & ~main_load_c;

        main_valid_nx_c = main_load_c ? main_valid_d_c : main_valid;
        skid_valid_nx_c = skid_en_c ? skid_valid_d_c : skid_valid;
        count_d_c       = occupancy(main_valid_nx_c, skid_valid_nx_c);
    end

    dffe_sr #(.WIDTH(1), .RST_VAL(1'b0)) u_main_valid (
        .clk (clk),
        .rst (clr_c),
        .en  (main_load_c),
        .d   (main_valid_d_c),
        .q   (main_valid)
    );

    dffe_sr #(.WIDTH(WIDTH), .RST_VAL(BUBBLE_W)) u_main_data (
        .clk (clk),
        .rst (clr_c),
        .en  (main_load_c),
        .d   (main_data_d_c),
        .q   (main_data)
    );

    dffe_sr #(.WIDTH(1), .RST_VAL(1'b0)) u_skid_valid (
        .clk (clk),
        .rst (clr_c),
        .en  (skid_en_c),
        .d   (skid_valid_d_c),
        .q   (skid_valid)
    );

    dffe_sr #(.WIDTH(WIDTH), .RST_VAL(BUBBLE_W)) u_skid_data (
        .clk (clk),
        .rst (clr_c),
        .en  (skid_data_en_c),
        .d   (in_data),
        .q   (skid_data)
    );

    // Occupancy and ready kept in their own flops so both are plain register outputs.
    dffe_sr #(.WIDTH(2), .RST_VAL(2'd0)) u_count (
        .clk (clk),
        .rst (clr_c),
        .en  (1'b1),
        .d   (count_d_c),
        .q   (count)
    );

    dffe_sr #(.WIDTH(1), .RST_VAL(1'b1)) u_in_ready (
        .clk (clk),
        .rst (clr_c),
        .en  (1'b1),
        .d   (~skid_valid_nx_c),
        .q   (in_ready)
    );

    assign out_valid = main_valid;
    assign out_data  = main_data;

endmodule

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 Parameter WIDTH, default 32 (XLEN); payload width in bits.
REQ-002 Parameter BUBBLE, default 32'h0000_0013 (RV32I NOP, addi x0,x0,0); payload value driven when no valid entry is held, zero-extended or truncated to WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  kill all held entries and any entry offered this cycle.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_data  input  WIDTH  upstream payload (packed pc/pc+4/instr/rd bundle).
REQ-008 in_ready  output  1  stage can accept; registered, not combinationally dependent on out_ready.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_data  output  WIDTH  downstream payload; registered.
REQ-011 out_ready  input  1  downstream accepts this cycle (0 = stall).
REQ-012 count  output  2  held entries, 0..2.

Function
REQ-013 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-014 Storage is two entries: main (drives out_*) and skid; in_ready = !skid_valid.
REQ-015 Main empty, or main transferring out: main loads from skid if skid_valid, else from the accepted input; the skid frees in the same cycle.
REQ-016 Main full, not transferring out, and input accepted: input is written to skid.
REQ-017 Latency: input accepted in cycle N appears on out_* in cycle N+1 when main is empty or draining.
REQ-018 Throughput: one transfer per cycle sustained while out_ready=1; no bubbles are inserted.
REQ-019 Order is strictly FIFO; no entry is dropped or duplicated except by flush/rst.
REQ-020 Stall (out_ready=0) holds out_valid/out_data stable until transfer (valid/ready stability rule).
REQ-021 in_ready falls one cycle after the skid fills and rises one cycle after it drains.
REQ-022 flush=1: next cycle out_valid=0, skid empty, count=0, in_ready=1, out_data=BUBBLE; an input offered in the flush cycle is discarded.
REQ-023 flush has priority over simultaneous in/out transfers; an output transfer in the flush cycle still counts downstream.
REQ-024 Whenever out_valid=0, out_data=BUBBLE, including after the last entry drains.
REQ-025 count = main_valid + skid_valid, registered and exact in every cycle.
REQ-026 in_valid while in_ready=0 has no effect; no overflow is possible.

Reset
REQ-027 rst=1 at an edge: out_valid=0, count=0, in_ready=1, out_data=BUBBLE, skid cleared, regardless of other inputs.
REQ-028 rst asserted mid-stall with 2 entries held discards both; the first acceptance is in the cycle after rst deasserts.
REQ-029 rst has priority over flush; both produce identical post-state.

Structure
REQ-030 BUBBLE default, NOP encoding and the IF/ID payload struct (pc, pc_p4, instr, rd) are defined in shared package pipe_pkg.
REQ-031 Storage uses one sub-module, dffe_sr (enable flop with synchronous active-high reset to a parameter value), instantiated for main and skid data/valid.
REQ-032 No latches and no combinational path from out_ready to in_ready.

Verification
REQ-033 Stream: in_data 0x100,0x104,0x108 on consecutive cycles, out_ready=1 -> out_data 0x100,0x104,0x108 one cycle later each, count=1, in_ready=1 throughout.
REQ-034 Stall: send 0xA,0xB with out_ready=0 -> count=2, in_ready=0 next cycle, out_data holds 0xA; raise out_ready -> 0xA then 0xB, in_ready=1 one cycle after 0xA leaves.
REQ-035 Flush with 2 held plus 0xC offered -> next cycle out_valid=0, out_data=0x00000013, count=0, 0xC never appears.
REQ-036 Drain to empty -> out_data=0x00000013 in the same cycle out_valid falls.
REQ-037 rst during full stall -> all outputs at reset values next cycle; post-reset 0x55 emerges exactly once.
REQ-038 Random in_valid/out_ready (10k cycles, scoreboard) -> exact in-order match, count never >2, out_* stable under stall.
